traffic_light_countdown: RTL and testbench

Traffic-phase sequencer with a per-second countdown. It cycles RED → GREEN → YELLOW, shows the seconds remaining in the current phase on `number`, and flashes yellow when disabled. It sits directly upstream of the two-digit 7-segment decoder: `number` and `disp_en` drive that decoder's `number` and `en` inputs. All outputs are registered.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 33 +++
 rtl/traffic_light_countdown.sv | 155 +++++++++++++++
 tb/tb_traffic_light_countdown.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-phase sequencer.
// Durations are in seconds; DECODER_MAX is the largest value the downstream 2-digit decoder shows.
package traffic_pkg;

  typedef enum logic [1:0] {
    FLASH  = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } traffic_state_e;

  localparam int DEF_NUMBER_WIDTH = 5;
  localparam int DEF_TICK_DIV     = 50_000_000;
  localparam int DEF_RED_TIME     = 15;
  localparam int DEF_GREEN_TIME   = 12;
  localparam int DEF_YELLOW_TIME  = 3;
  localparam int DEF_PED_MAX      = 4;
  localparam int DECODER_MAX      = 19;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..pTICK_DIV-1, tick is high while the count sits at the top value.
// clear forces the count back to 0 on the next edge so a new phase starts a full second.
module tick_prescaler #(
  parameter int pTICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(pTICK_DIV);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(pTICK_DIV - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_light_countdown.sv
// Traffic-phase sequencer RED -> GREEN -> YELLOW with a per-second countdown on number.
// Flashing yellow while disabled; pedestrian requests can only shorten GREEN.
module traffic_light_countdown
  import traffic_pkg::*;
#(
  parameter int pNUMBER_WIDTH = DEF_NUMBER_WIDTH,
  parameter int pTICK_DIV     = DEF_TICK_DIV,
  parameter int pRED_TIME     = DEF_RED_TIME,
  parameter int pGREEN_TIME   = DEF_GREEN_TIME,
  parameter int pYELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int pPED_MAX      = DEF_PED_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     ped_req,
  output logic                     red,
  output logic                     yellow,
  output logic                     green,
  output logic [pNUMBER_WIDTH-1:0] number,
  output logic                     disp_en
);

  localparam int W = pNUMBER_WIDTH;
  localparam logic [W-1:0] RED_LD    = W'(pRED_TIME);
  localparam logic [W-1:0] GREEN_LD  = W'(pGREEN_TIME);
  localparam logic [W-1:0] YELLOW_LD = W'(pYELLOW_TIME);
  localparam logic [W-1:0] PED_LD    = W'(pPED_MAX);
  localparam logic [W-1:0] PED_ENTRY = W'(min_int(pGREEN_TIME, pPED_MAX));

  if (pTICK_DIV < 2) begin : g_chk_div
    $error("pTICK_DIV must be at least 2");
  end
  if (pRED_TIME < 1 || pRED_TIME > DECODER_MAX) begin : g_chk_red
    $error("pRED_TIME out of range");
  end
  if (pGREEN_TIME < 1 || pGREEN_TIME > DECODER_MAX) begin : g_chk_green
    $error("pGREEN_TIME out of range");
  end
  if (pYELLOW_TIME < 1 || pYELLOW_TIME > DECODER_MAX) begin : g_chk_yellow
    $error("pYELLOW_TIME out of range");
  end
  if (pPED_MAX < 1 || pPED_MAX > pGREEN_TIME - 1) begin : g_chk_ped
    $error("pPED_MAX out of range");
  end
  if (DECODER_MAX >= (1 << pNUMBER_WIDTH)) begin : g_chk_width
    $error("pNUMBER_WIDTH too narrow for the duration range");
  end

  traffic_state_e state_q;
  logic [W-1:0]   number_q;
  logic           red_q, yellow_q, green_q, disp_en_q;
  logic           flash_q, ped_q;

  logic           tick;
  logic           presc_clear_d;
  logic           ped_any_d;
  logic [W-1:0]   green_dec_d;
  logic [W-1:0]   green_next_d;

  // Restart the second on FLASH->RED and on any running->FLASH drop.
  assign presc_clear_d = (state_q == FLASH) ? en : !en;
  assign ped_any_d     = ped_q | ped_req;
  assign green_dec_d   = tick ? (number_q - W'(1)) : number_q;
  assign green_next_d  = (ped_any_d && (green_dec_d > PED_LD)) ? PED_LD : green_dec_d;

  tick_prescaler #(
    .pTICK_DIV(pTICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(presc_clear_d),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FLASH;
      number_q  <= '0;
      red_q     <= 1'b0;
      yellow_q  <= 1'b0;
      green_q   <= 1'b0;
      disp_en_q <= 1'b0;
      flash_q   <= 1'b0;
      ped_q     <= 1'b0;
    end else begin
      case (state_q)
        FLASH: begin
          ped_q <= 1'b0;
          if (en) begin
            state_q   <= RED;
            number_q  <= RED_LD;
            red_q     <= 1'b1;
            yellow_q  <= 1'b0;
            green_q   <= 1'b0;
            disp_en_q <= 1'b1;
            flash_q   <= 1'b0;
          end else if (tick) begin
            flash_q  <= !flash_q;
            yellow_q <= !flash_q;
          end
        end
        default: begin
          if (!en) begin
            state_q   <= FLASH;
            red_q     <= 1'b0;
            yellow_q  <= 1'b0;
            green_q   <= 1'b0;
            disp_en_q <= 1'b0;
            flash_q   <= 1'b0;
            ped_q     <= 1'b0;
          end else if (tick && (number_q == W'(1))) begin
            red_q    <= 1'b0;
            yellow_q <= 1'b0;
            green_q  <= 1'b0;
            case (state_q)
              RED: begin
                state_q  <= GREEN;
                green_q  <= 1'b1;
                number_q <= ped_any_d ? PED_ENTRY : GREEN_LD;
                ped_q    <= 1'b0;
              end
              GREEN: begin
                // A request arriving on the last GREEN second is simply dropped.
                state_q  <= YELLOW;
                yellow_q <= 1'b1;
                number_q <= YELLOW_LD;
              end
              default: begin
                state_q  <= RED;
                red_q    <= 1'b1;
                number_q <= RED_LD;
                ped_q    <= ped_any_d;
              end
            endcase
          end else if (state_q == GREEN) begin
            number_q <= green_next_d;
          end else begin
            if (tick) begin
              number_q <= number_q - W'(1);
            end
            ped_q <= ped_any_d;
          end
        end
      endcase
    end
  end

  assign red     = red_q;
  assign yellow  = yellow_q;
  assign green   = green_q;
  assign number  = number_q;
  assign disp_en = disp_en_q;

endmodule

// File: tb/tb_traffic_light_countdown.sv
// Directed plus randomized bench for traffic_light_countdown against a phase/seconds reference model.
module tb_traffic_light_countdown;

  localparam int DIV = 4;
  localparam int PED = 2;
  int DUR [3] = '{3, 5, 2};   // RED, GREEN, YELLOW seconds

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic       red, yellow, green, disp_en;
  logic [4:0] number;

  int checks = 0;
  int errors = 0;

  // Reference model: running flag, phase index into DUR, seconds left, cycles into current second.
  bit m_run, m_flash, m_pend;
  int m_phase, m_rem, m_cyc;

  traffic_light_countdown #(
    .pNUMBER_WIDTH(5),
    .pTICK_DIV    (DIV),
    .pRED_TIME    (3),
    .pGREEN_TIME  (5),
    .pYELLOW_TIME (2),
    .pPED_MAX     (PED)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .ped_req(ped_req),
    .red    (red),
    .yellow (yellow),
    .green  (green),
    .number (number),
    .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_flash = 0; m_pend = 0; m_phase = 0; m_rem = 0; m_cyc = 0;
  endtask

  task automatic model_step(input bit e, input bit p);
    bit tick, want;
    int ncyc;
    tick = (m_cyc == DIV - 1);
    ncyc = tick ? 0 : m_cyc + 1;
    if (!m_run) begin
      m_pend = 0;
      if (e) begin
        m_run = 1; m_phase = 0; m_rem = DUR[0]; ncyc = 0;
      end else if (tick) begin
        m_flash = !m_flash;
      end
    end else if (!e) begin
      m_run = 0; m_flash = 0; m_pend = 0; ncyc = 0;
    end else begin
      want = p || m_pend;
      if (tick && m_rem == 1) begin
        m_phase = (m_phase + 1) % 3;
        if (m_phase == 1) begin
          m_rem  = want ? ((DUR[1] < PED) ? DUR[1] : PED) : DUR[1];
          m_pend = 0;
        end else begin
          m_rem = DUR[m_phase];
          if (m_phase == 0 && p) m_pend = 1;
        end
      end else if (m_phase == 1) begin
        if (tick) m_rem--;
        if (want && m_rem > PED) m_rem = PED;
      end else begin
        if (tick) m_rem--;
        if (p) m_pend = 1;
      end
    end
    m_cyc = ncyc;
  endtask

  task automatic check_model(input string tag);
    logic [8:0] exp;
    exp = {m_run && m_phase == 0,
           m_run ? (m_phase == 2) : m_flash,
           m_run && m_phase == 1,
           m_run,
           m_rem[4:0]};
    chk(tag, {23'b0, red, yellow, green, disp_en, number}, {23'b0, exp});
  endtask

  task automatic step(input bit e, input bit p);
    en = e;
    ped_req = p;
    @(posedge clk);
    model_step(e, p);
    #1;
    check_model("model");
    if (m_run) chk("one_lamp", 32'($countones({red, yellow, green})), 32'd1);
  endtask

  initial begin
    bit en_r;
    model_reset();
    #1;
    chk("reset_outputs", {27'b0, red, yellow, green, disp_en, number != 5'd0}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Enable: RED 3, full cycle back to RED.
    step(1, 0);
    chk("red_entry", {26'b0, red, green, number}, {26'b0, 1'b1, 1'b0, 5'd3});
    for (int i = 0; i < 41; i++) step(1, 0);
    chk("red_after_cycle", {26'b0, red, disp_en, number}, {26'b0, 1'b1, 1'b1, 5'd3});

    // Disable at GREEN 4 and observe the flash period.
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_phase == 1 && m_rem == 4) break;
      step(1, 0);
    end
    chk("green_at_4", {26'b0, green, number}, {26'b0, 1'b1, 5'd4});
    step(0, 0);
    chk("flash_entry", {29'b0, red, green, disp_en}, 32'd0);
    for (int k = 1; k < 12; k++) begin
      step(0, 0);
      chk("flash_yellow", {31'b0, yellow}, 32'((k / DIV) % 2));
    end
    step(1, 0);
    chk("reenable_red", {26'b0, red, disp_en, number}, {26'b0, 1'b1, 1'b1, 5'd3});

    // Pedestrian pulse at the first GREEN second.
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_phase == 1 && m_rem == 5) break;
      step(1, 0);
    end
    chk("green_at_5", {26'b0, green, number}, {26'b0, 1'b1, 5'd5});
    step(1, 1);
    chk("ped_clamp", {27'b0, number}, 32'd2);
    for (int i = 0; i < 8; i++) step(1, 0);
    chk("ped_to_yellow", {26'b0, yellow, number}, {26'b0, 1'b1, 5'd2});

    // Pedestrian request held over from RED.
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_phase == 0) break;
      step(1, 0);
    end
    step(1, 1);
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_phase == 1) break;
      step(1, 0);
    end
    chk("ped_green_entry", {26'b0, green, number}, {26'b0, 1'b1, 5'd2});

    // Request coincident with the final GREEN tick: YELLOW wins.
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_phase == 1 && m_rem == 1 && m_cyc == DIV - 1) break;
      step(1, 0);
    end
    step(1, 1);
    chk("ped_at_last_tick", {26'b0, yellow, number}, {26'b0, 1'b1, 5'd2});

    // Asynchronous reset mid-YELLOW.
    step(1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset", {27'b0, red, yellow, green, disp_en, number != 5'd0}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0);
    chk("red_after_reset", {26'b0, red, number}, {26'b0, 1'b1, 5'd3});

    // Randomized run against the model.
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) en_r = !en_r;
      step(en_r, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
